// File: rtl/icache_ctrl_pkg.sv
// Shared widths, state encodings and reset polarity for the instruction cache responder.
package icache_ctrl_pkg;

    localparam int ICacheIndexBits = 7;
    localparam int InstAddrBus     = 32;
    localparam int InstBus         = 32;

    typedef logic [1:0] ic_state_t;

    localparam ic_state_t IcIdle  = 2'b00;
    localparam ic_state_t IcFetch = 2'b01;
    localparam ic_state_t IcDone  = 2'b10;

    // This block resets on a low rst.
    localparam logic RstEnable = 1'b0;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and arbiter-side signals of the instruction cache; slave is the cache.
interface icache_ctrl_if #(
    parameter int ADDR_WIDTH = icache_ctrl_pkg::InstAddrBus
);
    logic [ADDR_WIDTH-1:0]           inst_addr_i;
    logic                            inst_enable_o;
    logic [icache_ctrl_pkg::InstBus-1:0] inst_data_o;
    logic                            inv_i;
    logic                            mem_req_o;
    logic [ADDR_WIDTH-1:0]           mem_addr_o;
    logic                            mem_valid_i;
    logic [7:0]                      mem_byte_i;

    modport master (
        output inst_addr_i, inv_i, mem_valid_i, mem_byte_i,
        input  inst_enable_o, inst_data_o, mem_req_o, mem_addr_o
    );

    modport slave (
        input  inst_addr_i, inv_i, mem_valid_i, mem_byte_i,
        output inst_enable_o, inst_data_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_ctrl_store.sv
// Line storage: valid bits, tags and data words with async read and sync write.
module icache_store
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = ICacheIndexBits,
    parameter int TAG_BITS   = InstAddrBus - ICacheIndexBits - 2,
    parameter int DATA_BITS  = InstBus
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [TAG_BITS-1:0]   wtag,
    input  logic [DATA_BITS-1:0]  wdata,
    input  logic                  wvalid,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic                  rvalid,
    output logic [TAG_BITS-1:0]   rtag,
    output logic [DATA_BITS-1:0]  rdata
);
    localparam int Depth = 1 << INDEX_BITS;

    logic [Depth-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [Depth];
    logic [DATA_BITS-1:0] data_q [Depth];

    // Clear-all beats a same-cycle write so invalidation always wins.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[widx] <= wvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped one-word-line instruction cache; refills a miss with four byte reads.
//  state   | meaning
//  IcIdle  | serve hits combinationally, start a fill on a miss
//  IcFetch | request bytes base+cnt, assemble little-endian word
//  IcDone  | line written, retry resolves as a hit next cycle
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = ICacheIndexBits,
    parameter int ADDR_WIDTH = InstAddrBus
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    icache_ctrl_if.slave bus
);
    localparam int TagBits = ADDR_WIDTH - INDEX_BITS - 2;

    ic_state_t             state;
    logic [1:0]            cnt;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] base;
    logic [23:0]           fill_buf;

    logic [INDEX_BITS-1:0] idx;
    logic [TagBits-1:0]    tag;
    logic                  line_valid;
    logic [TagBits-1:0]    line_tag;
    logic [InstBus-1:0]    line_data;
    logic                  hit_raw;
    logic                  idle_live;
    logic                  hit;
    logic                  miss_start;
    logic                  last_beat;
    logic                  clr;
    logic                  we;
    logic                  wvalid;

    assign idx = bus.inst_addr_i[INDEX_BITS+1:2];
    assign tag = bus.inst_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TagBits),
        .DATA_BITS  (InstBus)
    ) u_store (
        .clk    (clk),
        .clr    (clr),
        .we     (we),
        .widx   (base[INDEX_BITS+1:2]),
        .wtag   (base[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wdata  ({bus.mem_byte_i, fill_buf}),
        .wvalid (wvalid),
        .ridx   (idx),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data)
    );

    assign hit_raw    = line_valid && (line_tag == tag);
    assign idle_live  = (state == IcIdle) && rdy && !bus.inv_i;
    assign hit        = idle_live && hit_raw;
    assign miss_start = idle_live && !hit_raw;
    assign last_beat  = (state == IcFetch) && bus.mem_valid_i && (cnt == 2'd3);

    // A reset abandons the fill; an invalidate still writes the line but leaves it invalid.
    assign we     = (rst != RstEnable) && rdy && last_beat;
    assign wvalid = !drop && !bus.inv_i;
    assign clr    = (rst == RstEnable) || (rdy && bus.inv_i);

    assign bus.inst_enable_o = hit;
    assign bus.inst_data_o   = hit ? line_data : '0;
    assign bus.mem_req_o     = (state == IcFetch);
    assign bus.mem_addr_o    = base | {{(ADDR_WIDTH-2){1'b0}}, cnt};

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= IcIdle;
            cnt      <= 2'd0;
            drop     <= 1'b0;
            base     <= '0;
            fill_buf <= '0;
        end else if (rdy) begin
            case (state)
                IcIdle: begin
                    if (miss_start) begin
                        base  <= bus.inst_addr_i & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
                        cnt   <= 2'd0;
                        drop  <= 1'b0;
                        state <= IcFetch;
                    end
                end
                IcFetch: begin
                    if (bus.inv_i) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_valid_i) begin
                        case (cnt)
                            2'd0:    fill_buf[7:0]   <= bus.mem_byte_i;
                            2'd1:    fill_buf[15:8]  <= bus.mem_byte_i;
                            2'd2:    fill_buf[23:16] <= bus.mem_byte_i;
                            default: ;
                        endcase
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= IcDone;
                        end
                    end
                end
                IcDone:  state <= IcIdle;
                default: state <= IcIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a byte-memory arbiter model and expected-word queue.
module tb_icache_ctrl;
    import icache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    logic [7:0]  mem_m [logic [31:0]];

    icache_ctrl_if bus ();

    icache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : 8'h00;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            mem_m[a + 32'(k)] = w[k*8 +: 8];
        end
    endtask

    // Present addr until the cache answers; the arbiter model supplies bytes whenever asked.
    task automatic access(input logic [31:0] addr, input int exp_cyc, input int exp_beats,
                          input int stall_after, input int inv_at, input int rst_at,
                          input string tag);
        int  cyc;
        int  beat;
        int  stall_left;
        bit  done;
        bit  stall;
        bit  inv_done;
        bit  rst_done;
        bit  post_rst;
        logic [31:0] base;
        base       = {addr[31:2], 2'b00};
        cyc        = 0;
        beat       = 0;
        stall_left = 5;
        done       = 0;
        inv_done   = 0;
        rst_done   = 0;
        post_rst   = 0;
        bus.inst_addr_i = addr;
        exp_q.push_back(word_of(addr));
        while (!done && cyc < 60) begin
            @(negedge clk);
            stall = (beat == stall_after) && (stall_left > 0);
            rdy   = !stall;
            #1;
            if (post_rst) begin
                check({tag, "_req_after_rst"}, 32'(bus.mem_req_o), 32'd0);
                post_rst = 0;
            end
            if (stall) begin
                check({tag, "_stall_addr"}, bus.mem_addr_o, base + 32'(beat % 4));
                check({tag, "_stall_req"}, 32'(bus.mem_req_o), 32'd1);
                stall_left--;
            end else if (bus.inst_enable_o) begin
                check({tag, "_data"}, bus.inst_data_o, exp_q.pop_front());
                check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
                check({tag, "_req_on_hit"}, 32'(bus.mem_req_o), 32'd0);
                done = 1;
            end else if (bus.mem_req_o) begin
                check({tag, "_maddr"}, bus.mem_addr_o, base + 32'(beat % 4));
                bus.mem_valid_i = 1'b1;
                bus.mem_byte_i  = mem_byte(bus.mem_addr_o);
                if (beat == inv_at && !inv_done) begin
                    bus.inv_i = 1'b1;
                    inv_done  = 1;
                end
                beat++;
                if (beat - 1 == rst_at && !rst_done) begin
                    rst      = 1'b0;
                    rst_done = 1;
                    post_rst = 1;
                    beat     = 0;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_valid_i = 1'b0;
            bus.inv_i       = 1'b0;
            rst             = 1'b1;
            rdy             = 1'b1;
            cyc++;
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        check({tag, "_beats"}, 32'(beat), 32'(exp_beats));
    endtask

    initial begin
        bus.inst_addr_i = 32'h0;
        bus.inv_i       = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_byte_i  = 8'h00;

        set_word(32'h0000_0004, 32'h0000_0513);
        set_word(32'h0000_0204, 32'h0010_0093);
        set_word(32'h0000_0008, 32'hDEAD_BEEF);
        set_word(32'h0000_000C, 32'hCAFE_F00D);
        set_word(32'h0000_0010, 32'h1234_5678);
        set_word(32'h0000_0014, 32'hA5C3_0F96);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",    32'(bus.mem_req_o),     32'd0);
        check("rst_addr",   bus.mem_addr_o,         32'd0);
        check("rst_enable", 32'(bus.inst_enable_o), 32'd0);
        check("rst_data",   bus.inst_data_o,        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        access(32'h0000_0004, 6, 4, -1, -1, -1, "cold_miss");
        access(32'h0000_0004, 0, 0, -1, -1, -1, "hit");
        access(32'h0000_0204, 6, 4, -1, -1, -1, "alias_fill");
        access(32'h0000_0004, 6, 4, -1, -1, -1, "alias_remiss");
        access(32'h0000_0008, 11, 4, 1, -1, -1, "rdy_stall");
        access(32'h0000_0008, 0, 0, -1, -1, -1, "stall_hit");
        access(32'h0000_0010, 12, 8, -1, 1, -1, "inv_mid_fill");
        access(32'h0000_0008, 6, 4, -1, -1, -1, "after_inv");

        // Invalidate while idle on a resident line: no hit that cycle, then a fresh miss.
        bus.inst_addr_i = 32'h0000_0008;
        @(negedge clk);
        bus.inv_i = 1'b1;
        #1;
        check("inv_idle_enable", 32'(bus.inst_enable_o), 32'd0);
        check("inv_idle_data",   bus.inst_data_o,        32'd0);
        @(posedge clk);
        #1;
        bus.inv_i = 1'b0;
        access(32'h0000_0008, 6, 4, -1, -1, -1, "after_inv_idle");

        access(32'h0000_000C, 9, 4, -1, -1, 1, "rst_mid_fill");
        access(32'h0000_0008, 6, 4, -1, -1, -1, "after_rst");
        access(32'h0000_0014, 12, 8, -1, 3, -1, "inv_last_beat");
        access(32'h0000_0014, 0, 0, -1, -1, -1, "final_hit");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
